uart_ctrl: RTL and testbench

Bus-master sequencer for the MiniUART single-cycle slave port (ADD[4:2], STB, WE, 32-bit data, no ACK). After reset it programs the RX/TX baud divisors. It then polls LSR, drains received bytes into a one-entry buffer, and shares the transmitter between two byte requesters with round-robin arbitration. The CPU console path and a hardware logger both sit behind it, so neither talks to the UART directly.

---
 rtl/uart_ctrl_pkg.sv | 29 ++
 rtl/uart_ctrl_if.sv | 18 +
 rtl/uart_ctrl_rr_arb2.sv | 29 ++
 rtl/uart_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: MiniUART register offsets, LSR bit indices and controller states
//   REG_*   : 3-bit register offsets driven onto the UART ADD[4:2] lines
//   LSR_*   : bit positions inside the line status register
//   state_t : sequencer states shared by the controller and its bench
package uart_ctrl_pkg;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_IER  = 3'd1;
    localparam logic [2:0] REG_IIR  = 3'd2;
    localparam logic [2:0] REG_LCR  = 3'd3;
    localparam logic [2:0] REG_LSR  = 3'd4;
    localparam logic [2:0] REG_MSR  = 3'd5;
    localparam logic [2:0] REG_DIVR = 3'd6;
    localparam logic [2:0] REG_DIVT = 3'd7;

    localparam int LSR_TS = 5;
    localparam int LSR_RS = 0;

    typedef enum logic [2:0] {
        CFG_DIVR,
        CFG_DIVT,
        IDLE,
        TX_WRITE,
        RX_READ,
        RX_CLR,
        GUARD
    } state_t;

endpackage

// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: single-cycle MiniUART slave port (no acknowledge)
//   adr  : register offset (UART ADD[4:2])
//   wdat : write data to the UART
//   rdat : combinational read data from the UART
//   stb  : strobe, access completes in the cycle it is asserted
//   we   : write enable
interface uart_ctrl_if;

    logic [2:0]  adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        stb;
    logic        we;

    modport master (output adr, wdat, stb, we, input rdat);
    modport slave  (input adr, wdat, stb, we, output rdat);

endinterface

// File: rtl/uart_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter
//   CLK_I, RST_I : clock, asynchronous active-high reset
//   req[1:0]     : request lines
//   advance      : the current grant is being consumed, move the pointer
//   grant[1:0]   : one-hot grant (zero when nothing is requested)
module rr_arb2 (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr=0 favours requester 0, ptr=1 favours requester 1
    logic ptr;

    always_comb begin
        grant[0] = req[0] & (~ptr | ~req[1]);
        grant[1] = req[1] & (ptr | ~req[0]);
    end

    // After a grant the favoured side becomes the one that was not served
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I)
            ptr <= 1'b0;
        else if (advance)
            ptr <= grant[0];

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: MiniUART bus-master sequencer (divisor setup, RX drain, shared TX)
//   CLK_I, RST_I       : clock, asynchronous active-high reset
//   uart               : master side of the UART slave port
//   txN_req/txN_data   : byte requesters, data stable while req is high
//   txN_ack            : one-cycle pulse when the byte is written to DATA
//   rx_data/rx_valid   : received byte, held until rx_valid&rx_ready
//   cfg_done           : divisors programmed, controller operational
//   tx_cnt/rx_cnt      : only with UART_CTRL_STAT_EN, wrapping access counters
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter logic [15:0] DIVR_VAL  = 16'd325,
    parameter logic [15:0] DIVT_VAL  = 16'd5208,
    parameter int unsigned GUARD_CYC = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    uart_ctrl_if.master uart,
    input  logic        tx0_req,
    input  logic [7:0]  tx0_data,
    output logic        tx0_ack,
    input  logic        tx1_req,
    input  logic [7:0]  tx1_data,
    output logic        tx1_ack,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
`ifdef UART_CTRL_STAT_EN
    output logic [15:0] tx_cnt,
    output logic [15:0] rx_cnt,
`endif
    output logic        cfg_done
);

    state_t      state, nxt;
    logic [3:0]  gcnt;
    logic [1:0]  grant, ack_n;
    logic        go_tx, stb_n, we_n;
    logic [2:0]  adr_n;
    logic [31:0] dat_n;

    wire unused_ok = &{1'b0, uart.rdat[31:8]};

    rr_arb2 u_arb (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .req     ({tx1_req, tx0_req}),
        .advance (go_tx),
        .grant   (grant)
    );

    // Bus outputs are registered from the next state so that reset holds the
    // bus quiet; CFG_DIVR therefore waits until its write is actually on the bus.
    always_comb begin
        nxt   = state;
        go_tx = 1'b0;
        case (state)
            CFG_DIVR: nxt = uart.stb ? CFG_DIVT : CFG_DIVR;
            CFG_DIVT: nxt = GUARD;
            IDLE:
                if (uart.rdat[LSR_RS] && !rx_valid)
                    nxt = RX_READ;
                else if (uart.rdat[LSR_TS] && (tx0_req || tx1_req)) begin
                    nxt   = TX_WRITE;
                    go_tx = 1'b1;
                end
            TX_WRITE: nxt = GUARD;
            RX_READ:  nxt = RX_CLR;
            RX_CLR:   nxt = GUARD;
            GUARD:    nxt = (gcnt == 4'(GUARD_CYC - 1)) ? IDLE : GUARD;
            default:  nxt = CFG_DIVR;
        endcase
    end

    always_comb begin
        stb_n = 1'b0;
        we_n  = 1'b0;
        adr_n = REG_DATA;
        dat_n = '0;
        ack_n = 2'b00;
        case (nxt)
            CFG_DIVR: begin
                stb_n = 1'b1;
                we_n  = 1'b1;
                adr_n = REG_DIVR;
                dat_n = {16'b0, DIVR_VAL};
            end
            CFG_DIVT: begin
                stb_n = 1'b1;
                we_n  = 1'b1;
                adr_n = REG_DIVT;
                dat_n = {16'b0, DIVT_VAL};
            end
            IDLE: begin
                stb_n = 1'b1;
                adr_n = REG_LSR;
            end
            TX_WRITE: begin
                stb_n = 1'b1;
                we_n  = 1'b1;
                dat_n = {24'b0, grant[1] ? tx1_data : tx0_data};
                ack_n = grant;
            end
            RX_READ: stb_n = 1'b1;
            // Any write raises read_over in the UART, clearing rs and the IRQ
            RX_CLR: begin
                stb_n = 1'b1;
                we_n  = 1'b1;
                adr_n = REG_IIR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            state     <= CFG_DIVR;
            gcnt      <= '0;
            uart.stb  <= 1'b0;
            uart.we   <= 1'b0;
            uart.adr  <= '0;
            uart.wdat <= '0;
            tx0_ack   <= 1'b0;
            tx1_ack   <= 1'b0;
            cfg_done  <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            state     <= nxt;
            gcnt      <= (state == GUARD && nxt == GUARD) ? gcnt + 4'd1 : '0;
            uart.stb  <= stb_n;
            uart.we   <= we_n;
            uart.adr  <= adr_n;
            uart.wdat <= dat_n;
            tx0_ack   <= ack_n[0];
            tx1_ack   <= ack_n[1];
            cfg_done  <= cfg_done | (state == CFG_DIVT);
            if (state == RX_READ) begin
                rx_data  <= uart.rdat[7:0];
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
        end

`ifdef UART_CTRL_STAT_EN
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            tx_cnt <= tx_cnt + 16'(state == TX_WRITE);
            rx_cnt <= rx_cnt + 16'(state == RX_READ);
        end
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed self-checking bench for uart_ctrl with a small MiniUART model
module tb_uart_ctrl;
    import uart_ctrl_pkg::*;

    typedef struct packed {
        logic        we;
        logic [2:0]  adr;
        logic [31:0] dat;
        logic [1:0]  ack;
    } acc_t;

    localparam int GUARD = 2;

    logic CLK_I = 1'b0;
    logic RST_I = 1'b1;
    uart_ctrl_if u_bus ();

    logic       tx0_req, tx1_req, tx0_ack, tx1_ack, rx_valid, cfg_done;
    logic       rx_ready = 1'b0;
    logic [7:0] tx0_data, tx1_data, rx_data;
    logic [7:0] tx0_base = 8'h00, tx1_base = 8'h00, rx_byte = 8'h00;
    int         tx0_total = 0, tx1_total = 0, tx0_sent = 0, tx1_sent = 0;
    logic       ts_en = 1'b0, ts_on = 1'b0, rx_load = 1'b0, rx_pend = 1'b0;
    int         tx_busy = 0;
    logic       ts;
`ifdef UART_CTRL_STAT_EN
    logic [15:0] tx_cnt, rx_cnt;
`endif

    acc_t acc_log[$];
    int   checks = 0, failures = 0;
    int   gap = 100, guard_viol = 0, bad_ack = 0, pre_cfg = 0;

    always #5 CLK_I = ~CLK_I;

    assign tx0_req  = tx0_sent < tx0_total;
    assign tx1_req  = tx1_sent < tx1_total;
    assign tx0_data = tx0_base + 8'(tx0_sent);
    assign tx1_data = tx1_base + 8'(tx1_sent);
    assign ts       = ts_on && tx_busy == 0;
    assign u_bus.rdat = (u_bus.adr == REG_LSR)  ? {26'b0, ts, 4'b0, rx_pend} :
                        (u_bus.adr == REG_DATA) ? {24'b0, rx_byte} : 32'b0;

    uart_ctrl dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .uart     (u_bus),
        .tx0_req  (tx0_req),
        .tx0_data (tx0_data),
        .tx0_ack  (tx0_ack),
        .tx1_req  (tx1_req),
        .tx1_data (tx1_data),
        .tx1_ack  (tx1_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
`ifdef UART_CTRL_STAT_EN
        .tx_cnt   (tx_cnt),
        .rx_cnt   (rx_cnt),
`endif
        .cfg_done (cfg_done)
    );

    // UART and requester model: writes clear rs, DATA writes make TX busy
    always @(posedge CLK_I) begin
        ts_on <= ts_en;
        if (u_bus.stb && u_bus.we) rx_pend <= 1'b0;
        else if (rx_load) rx_pend <= 1'b1;
        if (u_bus.stb && u_bus.we && u_bus.adr == REG_DATA) tx_busy <= 6;
        else if (tx_busy != 0) tx_busy <= tx_busy - 1;
        if (tx0_ack) tx0_sent <= tx0_sent + 1;
        if (tx1_ack) tx1_sent <= tx1_sent + 1;
    end

    // Bus monitor: logs every non-LSR access and polices guard spacing and acks
    always @(negedge CLK_I) begin
        if (u_bus.stb && u_bus.we) gap = 0;
        else gap++;
        if (u_bus.stb && !cfg_done) pre_cfg++;
        if (u_bus.stb && !u_bus.we && u_bus.adr == REG_LSR) begin
            if (gap <= GUARD) guard_viol++;
        end else if (u_bus.stb)
            acc_log.push_back({u_bus.we, u_bus.adr, u_bus.wdat, tx1_ack, tx0_ack});
        if ((tx0_ack || tx1_ack) && !(u_bus.stb && u_bus.we && u_bus.adr == REG_DATA))
            bad_ack++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge CLK_I);
        #1;
    endtask

    task automatic wait_log(input int n, input string tag);
        int k = 0;
        while (acc_log.size() < n && k < 500) begin
            tick();
            k++;
        end
        check(tag, 64'(acc_log.size() >= n), 64'd1);
    endtask

    task automatic check_acc(input string tag, input int i, input logic we,
                             input logic [2:0] adr, input logic [31:0] dat, input logic [1:0] ack);
        if (i >= acc_log.size()) begin
            check({tag, "_missing"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_we_adr"}, {60'b0, acc_log[i].we, acc_log[i].adr}, {60'b0, we, adr});
            if (we) check({tag, "_dat"}, 64'(acc_log[i].dat), 64'(dat));
            check({tag, "_ack"}, 64'(acc_log[i].ack), 64'(ack));
        end
    endtask

    initial begin
        int s;
        repeat (3) tick();
        check("rst_stb", 64'(u_bus.stb), 64'd0);
        check("rst_we", 64'(u_bus.we), 64'd0);
        check("rst_adr", 64'(u_bus.adr), 64'd0);
        check("rst_dat", 64'(u_bus.wdat), 64'd0);
        check("rst_cfg_done", 64'(cfg_done), 64'd0);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_acks", {62'b0, tx1_ack, tx0_ack}, 64'd0);
        RST_I = 1'b0;

        // Configuration: exactly DIVR then DIVT, cfg_done in the following cycle
        wait_log(2, "cfg_timeout");
        check_acc("cfg_divr", 0, 1'b1, REG_DIVR, 32'd325, 2'b00);
        check_acc("cfg_divt", 1, 1'b1, REG_DIVT, 32'd5208, 2'b00);
        check("cfg_done_early", 64'(cfg_done), 64'd0);
        tick();
        check("cfg_done", 64'(cfg_done), 64'd1);
        repeat (5) tick();
        check("pre_cfg_accesses", 64'(pre_cfg), 64'd2);

        // Single byte from requester 0
        ts_en    = 1'b1;
        tx0_base = 8'h41 - 8'(tx0_sent);
        tx0_total++;
        s = acc_log.size();
        wait_log(s + 1, "tx0_timeout");
        check_acc("tx0_single", s, 1'b1, REG_DATA, 32'h41, 2'b01);
        repeat (10) tick();
        check("tx0_req_done", 64'(tx0_req), 64'd0);

        // Both requesters, four bytes each: pointer now favours requester 1
        tx0_base = 8'h10 - 8'(tx0_sent);
        tx1_base = 8'h20 - 8'(tx1_sent);
        tx0_total += 4;
        tx1_total += 4;
        s = acc_log.size();
        wait_log(s + 8, "rr_timeout");
        for (int i = 0; i < 8; i++)
            check_acc($sformatf("rr_%0d", i), s + i, 1'b1, REG_DATA,
                      (i % 2 == 0) ? 32'h20 + 32'(i / 2) : 32'h10 + 32'(i / 2),
                      (i % 2 == 0) ? 2'b10 : 2'b01);
        repeat (10) tick();

        // RX has priority when rs and ts rise together with tx0 pending
        ts_en    = 1'b0;
        repeat (10) tick();
        tx0_base = 8'h77 - 8'(tx0_sent);
        tx0_total++;
        repeat (3) tick();
        s = acc_log.size();
        check("no_tx_while_busy", 64'(s), 64'(acc_log.size()));
        rx_byte = 8'h5A;
        rx_load = 1'b1;
        ts_en   = 1'b1;
        tick();
        rx_load = 1'b0;
        wait_log(s + 3, "rxprio_timeout");
        check_acc("rxprio_read", s, 1'b0, REG_DATA, 32'h0, 2'b00);
        check_acc("rxprio_iir", s + 1, 1'b1, REG_IIR, 32'h0, 2'b00);
        check_acc("rxprio_tx", s + 2, 1'b1, REG_DATA, 32'h77, 2'b01);
        check("rx_data_5a", 64'(rx_data), 64'h5A);
        check("rx_valid_set", 64'(rx_valid), 64'd1);

        // Back-pressure: rs held while rx_valid is pending must not be read
        repeat (5) tick();
        rx_byte = 8'hA5;
        rx_load = 1'b1;
        tick();
        rx_load = 1'b0;
        s = acc_log.size();
        repeat (20) tick();
        check("rx_stall_no_read", 64'(acc_log.size()), 64'(s));
        check("rx_stall_valid", 64'(rx_valid), 64'd1);
        check("rx_stall_data", 64'(rx_data), 64'h5A);
        rx_ready = 1'b1;
        tick();
        check("rx_valid_cleared", 64'(rx_valid), 64'd0);
        rx_ready = 1'b0;
        wait_log(s + 2, "rx2_timeout");
        check_acc("rx2_read", s, 1'b0, REG_DATA, 32'h0, 2'b00);
        check_acc("rx2_iir", s + 1, 1'b1, REG_IIR, 32'h0, 2'b00);
        tick();
        check("rx_data_a5", 64'(rx_data), 64'hA5);
        check("rx_valid_a5", 64'(rx_valid), 64'd1);

        // Reset during GUARD right after a TX write
        repeat (10) tick();
        tx0_base = 8'h99 - 8'(tx0_sent);
        tx0_total++;
        s = acc_log.size();
        wait_log(s + 1, "tx_rst_timeout");
        check_acc("tx_before_rst", s, 1'b1, REG_DATA, 32'h99, 2'b01);
        tick();
`ifdef UART_CTRL_STAT_EN
        check("tx_cnt", 64'(tx_cnt), 64'd11);
        check("rx_cnt", 64'(rx_cnt), 64'd2);
`endif
        RST_I = 1'b1;
        #1;
        check("mid_rst_stb", 64'(u_bus.stb), 64'd0);
        check("mid_rst_cfg_done", 64'(cfg_done), 64'd0);
        check("mid_rst_rx_valid", 64'(rx_valid), 64'd0);
        check("mid_rst_rx_data", 64'(rx_data), 64'd0);
        check("mid_rst_dat", 64'(u_bus.wdat), 64'd0);
`ifdef UART_CTRL_STAT_EN
        check("mid_rst_tx_cnt", 64'(tx_cnt), 64'd0);
        check("mid_rst_rx_cnt", 64'(rx_cnt), 64'd0);
`endif
        repeat (2) tick();
        s = acc_log.size();
        RST_I = 1'b0;
        wait_log(s + 2, "recfg_timeout");
        check_acc("recfg_divr", s, 1'b1, REG_DIVR, 32'd325, 2'b00);
        check_acc("recfg_divt", s + 1, 1'b1, REG_DIVT, 32'd5208, 2'b00);
        repeat (8) tick();
        check("recfg_done", 64'(cfg_done), 64'd1);
        check("pre_cfg_total", 64'(pre_cfg), 64'd4);
        check("guard_violations", 64'(guard_viol), 64'd0);
        check("stray_acks", 64'(bad_ack), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
